coef_hex_tx: RTL and testbench

Formatter stage placed directly upstream of the UART transmitter. It accepts 16-bit DCT coefficient words over a strobe/acknowledge handshake and renders each word as four uppercase ASCII hex digits, most significant nibble first. After each word it emits a separator: a space, or CR LF at the end of every line of WORDS_PER_LINE words. Characters go out one byte at a time on the same strobe/acknowledge handshake the UART transmitter accepts.

---
 rtl/coef_hex_tx_if.sv | 19 +
 rtl/coef_hex_tx.sv | 136 +++++++++++++
 tb/tb_coef_hex_tx.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coef_hex_tx_if.sv
`timescale 1ns/1ps
// coef_hex_tx_if
// Strobe/acknowledge byte or word channel shared by the coefficient producer
// side and the UART transmitter side of coef_hex_tx.
//   stb : strobe from the sender, held with dat until acknowledged
//   dat : payload, W bits wide
//   ack : one-cycle acknowledge from the receiver
// modport master : the side that sends (drives stb/dat, samples ack)
// modport slave  : the side that receives (samples stb/dat, drives ack)
interface coef_hex_tx_if #(
   parameter int unsigned W = 8
) ();
   logic         stb;
   logic [W-1:0] dat;
   logic         ack;

   modport master (output stb, output dat, input  ack);
   modport slave  (input  stb, input  dat, output ack);
endinterface

// File: rtl/coef_hex_tx.sv
`timescale 1ns/1ps
// coef_hex_tx
// Formatter placed in front of the UART transmitter. Each 16-bit coefficient
// taken from the producer is rendered as four uppercase ASCII hex digits,
// most significant nibble first, followed by a space, or by CR LF when the
// word is the last one of a WORDS_PER_LINE-word text line.
// Ports:
//   CLK   : system clock, rising edge
//   RSTn  : asynchronous active-low reset
//   src   : coefficient input channel (slave), dat is 16 bits;
//           src.ack pulses for one cycle when the word is captured
//   uart  : character output channel (master), dat is 8 bits;
//           uart.stb holds until uart.ack is seen, then drops for one cycle
//   BUSY  : high while a word is being emitted
// All outputs are registered; no input reaches an output combinationally.
module coef_hex_tx #(
   parameter int unsigned WORDS_PER_LINE = 8
) (
   input  logic          CLK,
   input  logic          RSTn,
   coef_hex_tx_if.slave  src,
   coef_hex_tx_if.master uart,
   output logic          BUSY
);

   localparam logic [7:0] LAST_COL = 8'(WORDS_PER_LINE - 1);

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t      state;
   logic [15:0] word;
   logic [2:0]  idx;
   logic [7:0]  cnt;
   logic        ack_r;
   logic        stb_r;
   logic [7:0]  dat_r;

   logic        at_eol;
   logic [7:0]  next_char;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end else begin
         // 0x37 + 10 = 'A'
         return 8'h37 + {4'h0, nib};
      end
   endfunction

   // Current word closes the line: its separator is CR and an LF follows.
   assign at_eol = (cnt == LAST_COL);

   // Character that follows the one at idx; consumed only in GAP.
   always_comb begin
      next_char = '0;
      case (idx)
         3'd0:    next_char = hex_char(word[11:8]);
         3'd1:    next_char = hex_char(word[7:4]);
         3'd2:    next_char = hex_char(word[3:0]);
         3'd3:    next_char = at_eol ? CH_CR : CH_SPACE;
         default: next_char = CH_LF;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
         word  <= '0;
         idx   <= '0;
         cnt   <= '0;
         ack_r <= 1'b0;
         stb_r <= 1'b0;
         dat_r <= '0;
      end else begin
         ack_r <= 1'b0;
         case (state)
            IDLE: begin
               if (src.stb) begin
                  word  <= src.dat;
                  ack_r <= 1'b1;
                  idx   <= '0;
                  stb_r <= 1'b1;
                  // first digit comes straight from the bus: word is not loaded yet
                  dat_r <= hex_char(src.dat[15:12]);
                  state <= SEND;
               end
            end

            SEND: begin
               if (uart.ack) begin
                  stb_r <= 1'b0;
                  state <= GAP;
               end
            end

            GAP: begin
               if (idx < 3'd4) begin
                  idx   <= idx + 3'd1;
                  stb_r <= 1'b1;
                  dat_r <= next_char;
                  state <= SEND;
               end else if (idx == 3'd4) begin
                  if (at_eol) begin
                     idx   <= 3'd5;
                     stb_r <= 1'b1;
                     dat_r <= CH_LF;
                     state <= SEND;
                  end else begin
                     cnt   <= cnt + 8'd1;
                     state <= IDLE;
                  end
               end else begin
                  cnt   <= '0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign src.ack  = ack_r;
   assign uart.stb = stb_r;
   assign uart.dat = dat_r;
   assign BUSY     = (state != IDLE);

endmodule

// File: tb/tb_coef_hex_tx.sv
`timescale 1ns/1ps
// Bench for coef_hex_tx: directed words, a queue-based character model and a
// per-cycle compare process, plus literal character strings for each test.
module tb_coef_hex_tx;

   localparam int unsigned WPL = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   coef_hex_tx_if #(.W(16)) src ();
   coef_hex_tx_if #(.W(8))  uart ();

   coef_hex_tx #(.WORDS_PER_LINE(WPL)) dut (
      .CLK  (clk),
      .RSTn (rst_n),
      .src  (src),
      .uart (uart),
      .BUSY (busy)
   );

   always #5 clk = ~clk;

   // model state
   byte unsigned exp_q[$];
   byte unsigned log_q[$];
   byte unsigned want_q[$];
   int unsigned  line_words = 0;
   bit           took_prev  = 0;
   bit           ack_prev   = 0;
   int unsigned  acki_cnt   = 0;
   int unsigned  stb_run    = 0;
   int unsigned  last_run   = 0;

   // UART acknowledge responder configuration
   int unsigned  ack_delay = 1;
   int unsigned  ack_hold  = 1;
   bit           force_ack = 0;
   int unsigned  wait_cnt  = 0;
   int unsigned  hold_left = 0;

   logic [15:0]  b2b_words [4];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic byte unsigned hex_ascii(input int unsigned d);
      return (d < 10) ? byte'(48 + d) : byte'(65 + d - 10);
   endfunction

   // Expected characters of one accepted word, line position tracked by count.
   task automatic model_word(input logic [15:0] w);
      int unsigned v;
      v = w;
      for (int i = 3; i >= 0; i--) exp_q.push_back(hex_ascii((v >> (4 * i)) % 16));
      if (line_words + 1 == WPL) begin
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         line_words = 0;
      end else begin
         exp_q.push_back(8'h20);
         line_words++;
      end
   endtask

   // Compare process and acknowledge responder, all on the falling edge.
   initial begin
      uart.ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            uart.ack = 1'($urandom_range(0, 1));
            check("rst_acki", 32'(src.ack), 0);
            check("rst_stbo", 32'(uart.stb), 0);
            check("rst_dato", 32'(uart.dat), 0);
            check("rst_busy", 32'(busy), 0);
            exp_q.delete();
            line_words = 0;
            took_prev  = 0;
            ack_prev   = 0;
            wait_cnt   = 0;
            hold_left  = 0;
            stb_run    = 0;
         end else begin
            if (force_ack) begin
               uart.ack = 1'b1;
            end else if (hold_left > 0) begin
               uart.ack = 1'b1;
               hold_left--;
            end else begin
               uart.ack = 1'b0;
               if (uart.stb) begin
                  wait_cnt++;
                  if (wait_cnt >= ack_delay) begin
                     uart.ack  = 1'b1;
                     hold_left = ack_hold - 1;
                     wait_cnt  = 0;
                  end
               end else begin
                  wait_cnt = 0;
               end
            end

            if (src.ack) begin
               acki_cnt++;
               // only from idle: no prior ACKi, no character in flight
               check("acki_idle", {29'd0, ack_prev, took_prev, exp_q.size() == 0}, 32'b001);
               model_word(src.dat);
            end
            ack_prev = src.ack;

            check("busy", 32'(busy), 32'((exp_q.size() > 0) || took_prev));
            check("stbo", 32'(uart.stb), 32'((exp_q.size() > 0) && !took_prev));
            if (uart.stb && exp_q.size() > 0) check("dato", 32'(uart.dat), 32'(exp_q[0]));

            if (uart.stb) stb_run++;
            else stb_run = 0;

            if (uart.stb && uart.ack) begin
               log_q.push_back(uart.dat);
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               last_run  = stb_run;
               took_prev = 1;
            end else begin
               took_prev = 0;
            end
         end
      end
   end

   task automatic send_word(input logic [15:0] w);
      bit seen;
      seen = 0;
      @(negedge clk); #1;
      src.stb = 1'b1;
      src.dat = w;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge clk); #1;
         seen = src.ack;
      end
      src.stb = 1'b0;
      check("acki_wait", 32'(seen), 1);
   endtask

   task automatic send_b2b();
      bit seen;
      @(negedge clk); #1;
      src.stb = 1'b1;
      for (int k = 0; k < 4; k++) begin
         src.dat = b2b_words[k];
         seen = 0;
         for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk); #1;
            seen = src.ack;
         end
         check("b2b_acki_wait", 32'(seen), 1);
      end
      src.stb = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 0;
      for (int n = 0; n < 5000 && !done; n++) begin
         @(negedge clk); #2;
         done = (exp_q.size() == 0) && !busy && !uart.stb;
      end
      check({name, "_drain"}, 32'(done), 1);
   endtask

   task automatic want_str(input string s);
      for (int i = 0; i < s.len(); i++) want_q.push_back(s[i]);
   endtask

   task automatic want_crlf();
      want_q.push_back(8'h0D);
      want_q.push_back(8'h0A);
   endtask

   task automatic check_log(input string name);
      check({name, "_len"}, 32'(log_q.size()), 32'(want_q.size()));
      for (int i = 0; i < log_q.size() && i < want_q.size(); i++)
         check($sformatf("%s_char%0d", name, i), 32'(log_q[i]), 32'(want_q[i]));
      log_q.delete();
      want_q.delete();
   endtask

   initial begin
      int unsigned a0;
      bit          hit;

      rst_n   = 1'b0;
      src.stb = 1'b0;
      src.dat = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         src.stb = 1'($urandom_range(0, 1));
         src.dat = 16'($urandom);
      end
      src.stb = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single word
      log_q.delete();
      a0 = acki_cnt;
      send_word(16'h1A2F);
      wait_drain("single");
      check("single_acki", acki_cnt - a0, 1);
      want_q.push_back(8'h31); want_q.push_back(8'h41); want_q.push_back(8'h32);
      want_q.push_back(8'h46); want_q.push_back(8'h20);
      check_log("single");

      // line wrap, starting from column 0
      send_word(16'h7E57);
      wait_drain("filler");
      log_q.delete();
      send_word(16'h0000);
      send_word(16'hFFFF);
      send_word(16'h0123);
      wait_drain("wrap");
      want_str("0000 FFFF"); want_crlf(); want_str("0123 ");
      check_log("wrap");

      // back-to-back producer (column 1 at start)
      b2b_words[0] = 16'h1234;
      b2b_words[1] = 16'hABCD;
      b2b_words[2] = 16'h0F0F;
      b2b_words[3] = 16'h9876;
      a0 = acki_cnt;
      send_b2b();
      wait_drain("b2b");
      check("b2b_acki", acki_cnt - a0, 4);
      want_str("1234"); want_crlf(); want_str("ABCD 0F0F"); want_crlf(); want_str("9876 ");
      check_log("b2b");

      // slow acknowledge
      ack_delay = 100;
      send_word(16'hC0DE);
      wait_drain("slow");
      check("slow_run", last_run, 100);
      want_str("C0DE"); want_crlf();
      check_log("slow");
      ack_delay = 1;

      // stuck acknowledge
      ack_hold = 10;
      send_word(16'hBEEF);
      wait_drain("stuck");
      check("stuck_run", last_run, 1);
      want_str("BEEF ");
      check_log("stuck");
      ack_hold = 1;

      // acknowledge held through idle
      force_ack = 1;
      repeat (5) @(negedge clk);
      send_word(16'h3C3C);
      wait_drain("force");
      force_ack = 0;
      want_str("3C3C"); want_crlf();
      check_log("force");

      // reset mid-word with one word already on the line
      send_word(16'h0001);
      wait_drain("pre_rst");
      log_q.delete();
      ack_delay = 4;
      send_word(16'h5555);
      hit = 0;
      for (int n = 0; n < 500 && !hit; n++) begin
         @(negedge clk); #1;
         hit = (log_q.size() == 2) && uart.stb;
      end
      check("rst_third_char", 32'(hit), 1);
      rst_n = 1'b0;
      #1;
      check("midrst_acki", 32'(src.ack), 0);
      check("midrst_stbo", 32'(uart.stb), 0);
      check("midrst_dato", 32'(uart.dat), 0);
      check("midrst_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      ack_delay = 1;
      log_q.delete();
      send_word(16'h00AB);
      wait_drain("post_rst");
      want_str("00AB ");
      check_log("post_rst");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
